// File: rtl/alu_cmd_sequencer.sv
// Command front end for the registered ALU: accept, wait the ALU latency, capture, respond.
// Optional SEQ_STICKY_OVF_EN adds a sticky overflow flag (ovf_sticky, ovf_clr).
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
`ifdef SEQ_STICKY_OVF_EN
  ,
  output logic              ovf_sticky,
  input  logic              ovf_clr
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [DATA_W-1:0]  acc_q;
  logic [DATA_W-1:0]  acc_d;
  logic [DATA_W-1:0]  a_d;
  logic [DATA_W-1:0]  b_d;
  logic [2:0]         op_d;
  logic [DATA_W-1:0]  res_d;
  logic [3:0]         flg_d;
  logic               vld_d;
  logic               capture;

  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = rst_n && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = alu_a;
    b_d     = alu_b;
    op_d    = alu_op;
    res_d   = rsp_result;
    flg_d   = rsp_flags;
    vld_d   = rsp_valid;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          b_d     = cmd_b;
          a_d     = cmd_use_acc ? acc_q : cmd_a;
          cnt_d   = CNT_W'(ALU_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          res_d   = alu_result;
          acc_d   = alu_result;
          flg_d   = {alu_overflow, alu_sign, alu_zero, alu_carry};
          vld_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
      alu_op     <= op_d;
      rsp_result <= res_d;
      rsp_flags  <= flg_d;
      rsp_valid  <= vld_d;
    end
  end

`ifdef SEQ_STICKY_OVF_EN
  // set beats clear when both land on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (capture && alu_overflow) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a registered ALU model and a result scoreboard.
// Define SEQ_STICKY_OVF_EN to also exercise the sticky overflow flag.
module tb_alu_cmd_sequencer;

  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_sign;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       busy;
  logic       ovf_sticky;
  logic       ovf_clr;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  exp_t sb[$];
  logic [7:0] tb_acc;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(8), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_use_acc  (cmd_use_acc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_sign     (alu_sign),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .busy         (busy)
`ifdef SEQ_STICKY_OVF_EN
    ,
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
`endif
  );

`ifndef SEQ_STICKY_OVF_EN
  assign ovf_sticky = 1'b0;
`endif

  // returns {ovf, sign, zero, carry, result}
  function automatic logic [11:0] alu_fn(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0];
        c = ~s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = {a[6:0], 1'b0};
        c = a[7];
      end
      3'd6: begin
        r = {1'b0, a[7:1]};
        c = a[0];
      end
      default: r = b;
    endcase
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  logic [11:0] alu_pipe [ALU_LAT];

  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_op);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end

  assign alu_result   = alu_pipe[ALU_LAT-1][7:0];
  assign alu_carry    = alu_pipe[ALU_LAT-1][8];
  assign alu_zero     = alu_pipe[ALU_LAT-1][9];
  assign alu_sign     = alu_pipe[ALU_LAT-1][10];
  assign alu_overflow = alu_pipe[ALU_LAT-1][11];

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ua,
                      input logic [7:0] ea, input logic [7:0] er,
                      input logic [3:0] ef);
    int n;
    sb.push_back(exp_t'({er, ef}));
    tb_acc      = er;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n >= 50) $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    else pass_cnt++;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_cnt++;
    if ({alu_a, alu_b, alu_op, busy} !== {ea, b, op, 1'b1})
      $display("FAIL alu_drive: a=%h b=%h op=%0d busy=%b required a=%h b=%h op=%0d busy=1",
               alu_a, alu_b, alu_op, busy, ea, b, op);
    else pass_cnt++;
  endtask

  task automatic wait_rsp(input bit chk_lat, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (!rsp_valid) $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    else pass_cnt++;
    if (chk_lat) begin
      chk_cnt++;
      if (lat !== ALU_LAT + 1)
        $display("FAIL rsp_latency: got %0d required %0d", lat, ALU_LAT + 1);
      else pass_cnt++;
    end
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
    chk_cnt++;
    if ({rsp_result, rsp_flags} !== {e.res, e.flg})
      $display("FAIL rsp_data: result=%h flags=%b required result=%h flags=%b",
               rsp_result, rsp_flags, e.res, e.flg);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, rsp_result, rsp_flags, cmd_ready, busy} !==
          {1'b1, e.res, e.flg, 1'b0, 1'b1})
        $display("FAIL backpressure_hold: vld=%b res=%h flg=%b rdy=%b busy=%b required 1 %h %b 0 1",
                 rsp_valid, rsp_result, rsp_flags, cmd_ready, busy, e.res, e.flg);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_cnt++;
    if ({rsp_valid, busy, cmd_ready, rsp_result} !== {1'b0, 1'b0, 1'b1, e.res})
      $display("FAIL rsp_release: vld=%b busy=%b rdy=%b res=%h required 0 0 1 %h",
               rsp_valid, busy, cmd_ready, rsp_result, e.res);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_flags, ovf_sticky} !== '0)
      $display("FAIL reset_state: rdy=%b busy=%b vld=%b a=%h b=%h op=%0d res=%h flg=%b sticky=%b required all 0",
               cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_flags, ovf_sticky);
    else pass_cnt++;
    rst_n  = 1'b1;
    tb_acc = 8'h00;
    @(negedge clk);
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_idle_ready: got %b required 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_add;
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80, 4'b1100);
    wait_rsp(1'b1, 0);
  endtask

  task automatic test_sub_shr;
    send(3'd1, 8'h05, 8'h05, 1'b0, 8'h05, 8'h00, 4'b0011);
    wait_rsp(1'b1, 0);
    send(3'd6, 8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 4'b0011);
    wait_rsp(1'b1, 0);
  endtask

  task automatic test_chain;
    send(3'd0, 8'h03, 8'h04, 1'b0, 8'h03, 8'h07, 4'b0000);
    wait_rsp(1'b1, 0);
    send(3'd5, 8'hFF, 8'h00, 1'b1, 8'h07, 8'h0E, 4'b0000);
    wait_rsp(1'b1, 0);
  endtask

  task automatic test_backpressure;
    send(3'd4, 8'hF0, 8'h3C, 1'b0, 8'hF0, 8'hCC, 4'b0100);
    cmd_valid   = 1'b1;
    cmd_op      = 3'd3;
    cmd_a       = 8'h01;
    cmd_b       = 8'h02;
    cmd_use_acc = 1'b0;
    wait_rsp(1'b1, 5);
    chk_cnt++;
    if (alu_a !== 8'hF0) $display("FAIL early_accept: alu_a=%h required f0", alu_a);
    else pass_cnt++;
    @(negedge clk);
    cmd_valid = 1'b0;
    sb.push_back(exp_t'({8'h03, 4'b0000}));
    tb_acc = 8'h03;
    chk_cnt++;
    if ({alu_a, alu_op, busy, cmd_ready} !== {8'h01, 3'd3, 1'b1, 1'b0})
      $display("FAIL held_cmd_accept: a=%h op=%0d busy=%b rdy=%b required 01 3 1 0",
               alu_a, alu_op, busy, cmd_ready);
    else pass_cnt++;
    wait_rsp(1'b1, 0);
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    send(3'd0, 8'h11, 8'h22, 1'b0, 8'h11, 8'h33, 4'b0000);
    rst_n = 1'b0;
    sb.delete();
    tb_acc = 8'h00;
    @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_flags} !== '0)
      $display("FAIL mid_wait_reset: rdy=%b busy=%b vld=%b a=%h b=%h op=%0d res=%h flg=%b required all 0",
               cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_flags);
    else pass_cnt++;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL discarded_rsp: rsp_valid seen=%b required 0", seen);
    else pass_cnt++;
    send(3'd0, 8'hAA, 8'h10, 1'b1, 8'h00, 8'h10, 4'b0000);
    wait_rsp(1'b1, 0);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ua;
    logic [7:0]  ea;
    logic [11:0] r;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ua = 1'($urandom_range(0, 1));
      ea = ua ? tb_acc : a;
      r  = alu_fn(ea, b, op);
      send(op, a, b, ua, ea, r[7:0], r[11:8]);
      wait_rsp(1'b1, i % 3);
    end
  endtask

`ifdef SEQ_STICKY_OVF_EN
  task automatic test_sticky;
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80, 4'b1100);
    wait_rsp(1'b1, 0);
    chk_cnt++;
    if (ovf_sticky !== 1'b1) $display("FAIL sticky_set: got %b required 1", ovf_sticky);
    else pass_cnt++;
    send(3'd2, 8'hFF, 8'h0F, 1'b0, 8'hFF, 8'h0F, 4'b0000);
    wait_rsp(1'b1, 0);
    chk_cnt++;
    if (ovf_sticky !== 1'b1) $display("FAIL sticky_hold: got %b required 1", ovf_sticky);
    else pass_cnt++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk_cnt++;
    if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear: got %b required 0", ovf_sticky);
    else pass_cnt++;
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80, 4'b1100);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk_cnt++;
    if ({rsp_valid, ovf_sticky} !== 2'b11)
      $display("FAIL sticky_set_wins: vld=%b sticky=%b required 1 1", rsp_valid, ovf_sticky);
    else pass_cnt++;
    wait_rsp(1'b0, 0);
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b0;
    ovf_clr     = 1'b0;
    tb_acc      = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_shr();
    test_chain();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef SEQ_STICKY_OVF_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
